// File: rtl/npc_pkg.sv
// Shared decode definitions for the IDU: opcode constants, one-hot bit
// positions of every control field, and the decoded FIFO word.
// Optional feature macro: IDU_RV32M_EN (adds the mdu_op field to dec_bundle_t).
package npc_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [6:0] F7_BASE   = 7'h00;
  localparam logic [6:0] F7_ALT    = 7'h20;
  localparam logic [6:0] F7_MULDIV = 7'h01;

  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_MRET   = 32'h3020_0073;

  localparam int ALU_ADD = 0, ALU_SUB = 1, ALU_SLT = 2, ALU_SLTU = 3, ALU_AND = 4;
  localparam int ALU_OR  = 5, ALU_XOR = 6, ALU_SLL = 7, ALU_SRL  = 8, ALU_SRA = 9;

  localparam int MDU_MUL = 0, MDU_MULH = 1, MDU_MULHSU = 2, MDU_MULHU = 3;
  localparam int MDU_DIV = 4, MDU_DIVU = 5, MDU_REM    = 6, MDU_REMU  = 7;

  localparam int JMP_JAL = 0, JMP_JALR = 1, JMP_BEQ  = 2, JMP_BNE  = 3;
  localparam int JMP_BLT = 4, JMP_BGE  = 5, JMP_BLTU = 6, JMP_BGEU = 7;

  localparam int MEM_SB = 0, MEM_SH = 1, MEM_SW  = 2, MEM_LB = 3;
  localparam int MEM_LH = 4, MEM_LW = 5, MEM_LBU = 6, MEM_LHU = 7;

  localparam int CSR_RW  = 0, CSR_RS  = 1, CSR_RC  = 2;
  localparam int CSR_RWI = 3, CSR_RSI = 4, CSR_RCI = 5;

  localparam int EXCP_ECALL = 0, EXCP_MRET = 1, EXCP_EBREAK = 2, EXCP_ILLEGAL = 3;

  localparam logic [2:0] SRC1_RS1  = 3'b001, SRC1_PC  = 3'b010, SRC1_ZERO = 3'b100;
  localparam logic [2:0] SRC2_RS2  = 3'b001, SRC2_IMM = 3'b010, SRC2_FOUR = 3'b100;
  localparam logic [2:0] WB_ALU    = 3'b001, WB_DRAM  = 3'b010, WB_CSR    = 3'b100;

  // One FIFO word. zimm is not stored: it is the rs1 field zero-extended.
  typedef struct packed {
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [9:0]  alu_op;
`ifdef IDU_RV32M_EN
    logic [7:0]  mdu_op;
`endif
    logic [7:0]  jump_type;
    logic [7:0]  mem_type;
    logic [2:0]  sel_alu_src1;
    logic [2:0]  sel_alu_src2;
    logic [2:0]  sel_rf_wdata;
    logic        rf_wen;
    logic        dram_en;
    logic        dram_wen;
    logic        csr_wen;
    logic [5:0]  csr_op;
    logic [3:0]  excp;
  } dec_bundle_t;

endpackage

// File: rtl/idu_pipe_if.sv
// IFU -> IDU -> EXU handshake bundle. slave is the decode stage's view,
// master is the view of whoever drives fetch and consumes decoded entries.
interface idu_pipe_if #(parameter int DEPTH = 4);
  logic                    in_valid;
  logic                    in_ready;
  logic [31:0]             in_inst;
  logic [31:0]             in_pc;
  logic                    flush;
  logic                    out_valid;
  logic                    out_ready;
  logic [31:0]             out_pc;
  logic [31:0]             out_imm;
  logic [4:0]              out_rs1;
  logic [4:0]              out_rs2;
  logic [4:0]              out_rd;
  logic [9:0]              out_alu_op;
  logic [7:0]              out_mdu_op;
  logic [7:0]              out_jump_type;
  logic [7:0]              out_mem_type;
  logic [2:0]              out_sel_alu_src1;
  logic [2:0]              out_sel_alu_src2;
  logic [2:0]              out_sel_rf_wdata;
  logic                    out_rf_wen;
  logic                    out_dram_en;
  logic                    out_dram_wen;
  logic                    out_csr_wen;
  logic [5:0]              out_csr_op;
  logic [31:0]             out_zimm;
  logic [3:0]              out_excp;
  logic [$clog2(DEPTH):0]  count;

  modport master (
    output in_valid, in_inst, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_pc, out_imm, out_rs1, out_rs2, out_rd,
           out_alu_op, out_mdu_op, out_jump_type, out_mem_type,
           out_sel_alu_src1, out_sel_alu_src2, out_sel_rf_wdata,
           out_rf_wen, out_dram_en, out_dram_wen, out_csr_wen,
           out_csr_op, out_zimm, out_excp, count
  );

  modport slave (
    input  in_valid, in_inst, in_pc, flush, out_ready,
    output in_ready, out_valid, out_pc, out_imm, out_rs1, out_rs2, out_rd,
           out_alu_op, out_mdu_op, out_jump_type, out_mem_type,
           out_sel_alu_src1, out_sel_alu_src2, out_sel_rf_wdata,
           out_rf_wen, out_dram_en, out_dram_wen, out_csr_wen,
           out_csr_op, out_zimm, out_excp, count
  );
endinterface

// File: rtl/idu_dec.sv
// Combinational RV32I(+M) decoder: raw instruction -> dec_bundle_t.
// Optional feature macro: IDU_RV32M_EN (funct7=0x01 R-type decodes to mdu_op).
module idu_dec
  import npc_pkg::*;
(
  input  logic [31:0]  inst,
  output dec_bundle_t  dec
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic signed [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic illegal;

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];

  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {inst[31:12], 12'b0};
  assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  // Field decode by opcode; anything unrecognised collapses to an illegal bundle.
  always_comb begin
    dec     = '0;
    illegal = 1'b0;
    dec.rs1 = inst[19:15];
    dec.rs2 = inst[24:20];
    dec.rd  = inst[11:7];
    case (opcode)
      OPC_LUI: begin
        dec.imm = imm_u;
        dec.alu_op[ALU_ADD] = 1'b1;
        dec.sel_alu_src1 = SRC1_ZERO;
        dec.sel_alu_src2 = SRC2_IMM;
        dec.sel_rf_wdata = WB_ALU;
        dec.rf_wen = 1'b1;
      end
      OPC_AUIPC: begin
        dec.imm = imm_u;
        dec.alu_op[ALU_ADD] = 1'b1;
        dec.sel_alu_src1 = SRC1_PC;
        dec.sel_alu_src2 = SRC2_IMM;
        dec.sel_rf_wdata = WB_ALU;
        dec.rf_wen = 1'b1;
      end
      OPC_JAL: begin
        dec.imm = imm_j;
        dec.jump_type[JMP_JAL] = 1'b1;
        dec.alu_op[ALU_ADD] = 1'b1;
        dec.sel_alu_src1 = SRC1_PC;
        dec.sel_alu_src2 = SRC2_FOUR;
        dec.sel_rf_wdata = WB_ALU;
        dec.rf_wen = 1'b1;
      end
      OPC_JALR: begin
        dec.imm = imm_i;
        dec.jump_type[JMP_JALR] = 1'b1;
        dec.alu_op[ALU_ADD] = 1'b1;
        dec.sel_alu_src1 = SRC1_PC;
        dec.sel_alu_src2 = SRC2_FOUR;
        dec.sel_rf_wdata = WB_ALU;
        dec.rf_wen = 1'b1;
        if (funct3 != 3'b000) illegal = 1'b1;
      end
      OPC_BRANCH: begin
        dec.imm = imm_b;
        dec.sel_alu_src1 = SRC1_RS1;
        dec.sel_alu_src2 = SRC2_RS2;
        case (funct3)
          3'b000: begin dec.jump_type[JMP_BEQ]  = 1'b1; dec.alu_op[ALU_SUB]  = 1'b1; end
          3'b001: begin dec.jump_type[JMP_BNE]  = 1'b1; dec.alu_op[ALU_SUB]  = 1'b1; end
          3'b100: begin dec.jump_type[JMP_BLT]  = 1'b1; dec.alu_op[ALU_SLT]  = 1'b1; end
          3'b101: begin dec.jump_type[JMP_BGE]  = 1'b1; dec.alu_op[ALU_SLT]  = 1'b1; end
          3'b110: begin dec.jump_type[JMP_BLTU] = 1'b1; dec.alu_op[ALU_SLTU] = 1'b1; end
          3'b111: begin dec.jump_type[JMP_BGEU] = 1'b1; dec.alu_op[ALU_SLTU] = 1'b1; end
          default: illegal = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        dec.imm = imm_i;
        dec.alu_op[ALU_ADD] = 1'b1;
        dec.sel_alu_src1 = SRC1_RS1;
        dec.sel_alu_src2 = SRC2_IMM;
        dec.sel_rf_wdata = WB_DRAM;
        dec.rf_wen  = 1'b1;
        dec.dram_en = 1'b1;
        case (funct3)
          3'b000:  dec.mem_type[MEM_LB]  = 1'b1;
          3'b001:  dec.mem_type[MEM_LH]  = 1'b1;
          3'b010:  dec.mem_type[MEM_LW]  = 1'b1;
          3'b100:  dec.mem_type[MEM_LBU] = 1'b1;
          3'b101:  dec.mem_type[MEM_LHU] = 1'b1;
          default: illegal = 1'b1;
        endcase
      end
      OPC_STORE: begin
        dec.imm = imm_s;
        dec.alu_op[ALU_ADD] = 1'b1;
        dec.sel_alu_src1 = SRC1_RS1;
        dec.sel_alu_src2 = SRC2_IMM;
        dec.dram_en  = 1'b1;
        dec.dram_wen = 1'b1;
        case (funct3)
          3'b000:  dec.mem_type[MEM_SB] = 1'b1;
          3'b001:  dec.mem_type[MEM_SH] = 1'b1;
          3'b010:  dec.mem_type[MEM_SW] = 1'b1;
          default: illegal = 1'b1;
        endcase
      end
      OPC_OP_IMM: begin
        dec.imm = imm_i;
        dec.sel_alu_src1 = SRC1_RS1;
        dec.sel_alu_src2 = SRC2_IMM;
        dec.sel_rf_wdata = WB_ALU;
        dec.rf_wen = 1'b1;
        case (funct3)
          3'b000: dec.alu_op[ALU_ADD]  = 1'b1;
          3'b010: dec.alu_op[ALU_SLT]  = 1'b1;
          3'b011: dec.alu_op[ALU_SLTU] = 1'b1;
          3'b100: dec.alu_op[ALU_XOR]  = 1'b1;
          3'b110: dec.alu_op[ALU_OR]   = 1'b1;
          3'b111: dec.alu_op[ALU_AND]  = 1'b1;
          3'b001: begin
            if (funct7 == F7_BASE) dec.alu_op[ALU_SLL] = 1'b1;
            else                   illegal = 1'b1;
          end
          default: begin
            if      (funct7 == F7_BASE) dec.alu_op[ALU_SRL] = 1'b1;
            else if (funct7 == F7_ALT)  dec.alu_op[ALU_SRA] = 1'b1;
            else                        illegal = 1'b1;
          end
        endcase
      end
      OPC_OP: begin
        dec.sel_alu_src1 = SRC1_RS1;
        dec.sel_alu_src2 = SRC2_RS2;
        dec.sel_rf_wdata = WB_ALU;
        dec.rf_wen = 1'b1;
        if (funct7 == F7_BASE) begin
          case (funct3)
            3'b000:  dec.alu_op[ALU_ADD]  = 1'b1;
            3'b001:  dec.alu_op[ALU_SLL]  = 1'b1;
            3'b010:  dec.alu_op[ALU_SLT]  = 1'b1;
            3'b011:  dec.alu_op[ALU_SLTU] = 1'b1;
            3'b100:  dec.alu_op[ALU_XOR]  = 1'b1;
            3'b101:  dec.alu_op[ALU_SRL]  = 1'b1;
            3'b110:  dec.alu_op[ALU_OR]   = 1'b1;
            default: dec.alu_op[ALU_AND]  = 1'b1;
          endcase
        end else if (funct7 == F7_ALT) begin
          case (funct3)
            3'b000:  dec.alu_op[ALU_SUB] = 1'b1;
            3'b101:  dec.alu_op[ALU_SRA] = 1'b1;
            default: illegal = 1'b1;
          endcase
`ifdef IDU_RV32M_EN
        end else if (funct7 == F7_MULDIV) begin
          // mdu_op bit order matches funct3 encoding directly.
          dec.mdu_op = 8'b1 << funct3;
`endif
        end else begin
          illegal = 1'b1;
        end
      end
      OPC_SYSTEM: begin
        case (funct3)
          3'b000: begin
            if      (inst == INST_ECALL)  dec.excp[EXCP_ECALL]  = 1'b1;
            else if (inst == INST_EBREAK) dec.excp[EXCP_EBREAK] = 1'b1;
            else if (inst == INST_MRET)   dec.excp[EXCP_MRET]   = 1'b1;
            else                          illegal = 1'b1;
          end
          3'b100: illegal = 1'b1;
          default: begin
            dec.imm = imm_i;
            dec.sel_alu_src1 = SRC1_RS1;
            dec.sel_rf_wdata = WB_CSR;
            dec.rf_wen  = 1'b1;
            dec.csr_wen = 1'b1;
            case (funct3)
              3'b001:  dec.csr_op[CSR_RW]  = 1'b1;
              3'b010:  dec.csr_op[CSR_RS]  = 1'b1;
              3'b011:  dec.csr_op[CSR_RC]  = 1'b1;
              3'b101:  dec.csr_op[CSR_RWI] = 1'b1;
              3'b110:  dec.csr_op[CSR_RSI] = 1'b1;
              default: dec.csr_op[CSR_RCI] = 1'b1;
            endcase
          end
        endcase
      end
      default: illegal = 1'b1;
    endcase

    // An illegal instruction carries only its register fields and the flag,
    // so no side-effect strobe can leak into execute.
    if (illegal) begin
      dec     = '0;
      dec.rs1 = inst[19:15];
      dec.rs2 = inst[24:20];
      dec.rd  = inst[11:7];
      dec.excp[EXCP_ILLEGAL] = 1'b1;
    end
  end

endmodule

// File: rtl/idu_pipe.sv
// Buffered decode stage: decodes each fetched instruction and queues the
// control bundle in a DEPTH-entry FIFO toward the EXU, with flush support.
// Optional feature macro: IDU_RV32M_EN (M-extension decode, mdu_op stored).
module idu_pipe
  import npc_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  idu_pipe_if.slave   bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  dec_bundle_t       dec_p0;
  dec_bundle_t       head_p1;
  logic [31:0]       head_pc_p1;
  dec_bundle_t       mem_dec [DEPTH];
  logic [31:0]       mem_pc  [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  cnt;
  logic              full, empty, rdy_p0, vld_p1, push, pop;

  // ---- stage p0: decode and FIFO write ----
  idu_dec u_dec (
    .inst (bus.in_inst),
    .dec  (dec_p0)
  );

  assign full   = (cnt == CNT_W'(DEPTH));
  assign empty  = (cnt == '0);
  assign rdy_p0 = !full && !bus.flush && !rst;
  assign vld_p1 = !empty && !bus.flush && !rst;
  assign push   = bus.in_valid && rdy_p0;
  assign pop    = vld_p1 && bus.out_ready;

  assign bus.in_ready  = rdy_p0;
  assign bus.out_valid = vld_p1;
  assign bus.count     = cnt;

  // Pointer and occupancy control; flush behaves like a reset of the queue.
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Payload storage; unreset because out_valid masks stale words.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_dec[wr_ptr] <= dec_p0;
      mem_pc[wr_ptr]  <= bus.in_pc;
    end
  end

  // ---- stage p1: head presentation ----
  assign head_p1    = mem_dec[rd_ptr];
  assign head_pc_p1 = mem_pc[rd_ptr];

  // Drive head payload when valid, otherwise hold every payload output at zero.
  always_comb begin
    bus.out_pc           = '0;
    bus.out_imm          = '0;
    bus.out_rs1          = '0;
    bus.out_rs2          = '0;
    bus.out_rd           = '0;
    bus.out_alu_op       = '0;
    bus.out_mdu_op       = '0;
    bus.out_jump_type    = '0;
    bus.out_mem_type     = '0;
    bus.out_sel_alu_src1 = '0;
    bus.out_sel_alu_src2 = '0;
    bus.out_sel_rf_wdata = '0;
    bus.out_rf_wen       = 1'b0;
    bus.out_dram_en      = 1'b0;
    bus.out_dram_wen     = 1'b0;
    bus.out_csr_wen      = 1'b0;
    bus.out_csr_op       = '0;
    bus.out_zimm         = '0;
    bus.out_excp         = '0;
    if (vld_p1) begin
      bus.out_pc           = head_pc_p1;
      bus.out_imm          = head_p1.imm;
      bus.out_rs1          = head_p1.rs1;
      bus.out_rs2          = head_p1.rs2;
      bus.out_rd           = head_p1.rd;
      bus.out_alu_op       = head_p1.alu_op;
`ifdef IDU_RV32M_EN
      bus.out_mdu_op       = head_p1.mdu_op;
`endif
      bus.out_jump_type    = head_p1.jump_type;
      bus.out_mem_type     = head_p1.mem_type;
      bus.out_sel_alu_src1 = head_p1.sel_alu_src1;
      bus.out_sel_alu_src2 = head_p1.sel_alu_src2;
      bus.out_sel_rf_wdata = head_p1.sel_rf_wdata;
      bus.out_rf_wen       = head_p1.rf_wen;
      bus.out_dram_en      = head_p1.dram_en;
      bus.out_dram_wen     = head_p1.dram_wen;
      bus.out_csr_wen      = head_p1.csr_wen;
      bus.out_csr_op       = head_p1.csr_op;
      bus.out_zimm         = {27'b0, head_p1.rs1};
      bus.out_excp         = head_p1.excp;
    end
  end

endmodule

// File: tb/tb_idu_pipe.sv
// Scoreboard bench for idu_pipe: directed instructions with hand-decoded
// expected bundles, backpressure, flush and mid-stream reset.
module tb_idu_pipe;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [9:0]  alu;
    logic [7:0]  mdu;
    logic [7:0]  jmp;
    logic [7:0]  mem;
    logic [2:0]  s1;
    logic [2:0]  s2;
    logic [2:0]  wd;
    logic [3:0]  strb;   // {rf_wen, dram_en, dram_wen, csr_wen}
    logic [5:0]  csr;
    logic [31:0] zimm;
    logic [3:0]  excp;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   accepted = 0;
  exp_t sb[$];
  exp_t cur_exp;

  idu_pipe_if #(.DEPTH(DEPTH)) bus();

  idu_pipe #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] imm,
                              input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                              input logic [9:0] alu, input logic [7:0] mdu,
                              input logic [7:0] jmp, input logic [7:0] mem,
                              input logic [2:0] s1, input logic [2:0] s2, input logic [2:0] wd,
                              input logic [3:0] strb, input logic [5:0] csr, input logic [3:0] excp);
    exp_t e;
    e.pc = pc; e.imm = imm; e.rs1 = rs1; e.rs2 = rs2; e.rd = rd;
    e.alu = alu; e.mdu = mdu; e.jmp = jmp; e.mem = mem;
    e.s1 = s1; e.s2 = s2; e.wd = wd; e.strb = strb; e.csr = csr;
    e.zimm = {27'b0, rs1}; e.excp = excp;
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] inst, input logic [31:0] pc, input exp_t e);
    bus.in_valid = 1'b1;
    bus.in_inst  = inst;
    bus.in_pc    = pc;
    cur_exp      = e;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    chk("drain_left", 64'(sb.size()), 64'd0);
  endtask

  // Issue side: record expectation for every accepted push; reset/flush drop all.
  always @(negedge clk) begin
    if (rst || bus.flush) begin
      sb.delete();
    end else if (bus.in_valid && bus.in_ready) begin
      sb.push_back(cur_exp);
      accepted++;
    end
  end

  // Monitor: compare each popped head against the oldest expectation.
  always @(negedge clk) begin
    exp_t act, e;
    if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      act = {bus.out_pc, bus.out_imm, bus.out_rs1, bus.out_rs2, bus.out_rd,
             bus.out_alu_op, bus.out_mdu_op, bus.out_jump_type, bus.out_mem_type,
             bus.out_sel_alu_src1, bus.out_sel_alu_src2, bus.out_sel_rf_wdata,
             bus.out_rf_wen, bus.out_dram_en, bus.out_dram_wen, bus.out_csr_wen,
             bus.out_csr_op, bus.out_zimm, bus.out_excp};
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got pc %0h, expected no entry", bus.out_pc);
      end else begin
        e = sb.pop_front();
        if (act !== e) begin
          errors++;
          $display("FAIL bundle_pc%0h: got %0h, expected %0h", e.pc, act, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  localparam int NV = 12;
  logic [31:0] vinst [NV];
  exp_t        vexp  [NV];

  initial begin
    bus.in_valid = 1'b0; bus.in_inst = '0; bus.in_pc = '0;
    bus.flush = 1'b0; bus.out_ready = 1'b0; cur_exp = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_count", 64'(bus.count), 64'd0);
    chk("rst_payload", {bus.out_pc, bus.out_imm}, 64'd0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

    // addi x1,x0,5 into empty FIFO: visible the cycle after the push
    step();
    bus.out_ready = 1'b1;
    drive(32'h0050_0093, 32'h1000,
          mk(32'h1000, 32'd5, 5'd0, 5'd5, 5'd1, 10'h001, 8'h00, 8'h00, 8'h00,
             3'b001, 3'b010, 3'b001, 4'b1000, 6'h00, 4'b0000));
    step();
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("lat_out_valid", 64'(bus.out_valid), 64'd1);
    chk("lat_count", 64'(bus.count), 64'd1);
    drain();

    // Mixed instruction stream at full rate
    vinst[0] = 32'h0080_A103; vexp[0] = mk(0, 32'd8, 5'd1, 5'd8, 5'd2, 10'h001, 8'h00, 8'h00, 8'h20, 3'b001, 3'b010, 3'b010, 4'b1100, 6'h00, 4'b0000);
    vinst[1] = 32'h0020_A223; vexp[1] = mk(0, 32'd4, 5'd1, 5'd2, 5'd4, 10'h001, 8'h00, 8'h00, 8'h04, 3'b001, 3'b010, 3'b000, 4'b0110, 6'h00, 4'b0000);
    vinst[2] = 32'h4020_81B3; vexp[2] = mk(0, 32'd0, 5'd1, 5'd2, 5'd3, 10'h002, 8'h00, 8'h00, 8'h00, 3'b001, 3'b001, 3'b001, 4'b1000, 6'h00, 4'b0000);
    vinst[3] = 32'h0020_8463; vexp[3] = mk(0, 32'd8, 5'd1, 5'd2, 5'd8, 10'h002, 8'h00, 8'h04, 8'h00, 3'b001, 3'b001, 3'b000, 4'b0000, 6'h00, 4'b0000);
    vinst[4] = 32'h1234_52B7; vexp[4] = mk(0, 32'h1234_5000, 5'd8, 5'd3, 5'd5, 10'h001, 8'h00, 8'h00, 8'h00, 3'b100, 3'b010, 3'b001, 4'b1000, 6'h00, 4'b0000);
    vinst[5] = 32'hFFF0_0093; vexp[5] = mk(0, 32'hFFFF_FFFF, 5'd0, 5'd31, 5'd1, 10'h001, 8'h00, 8'h00, 8'h00, 3'b001, 3'b010, 3'b001, 4'b1000, 6'h00, 4'b0000);
    vinst[6] = 32'h3001_10F3; vexp[6] = mk(0, 32'h300, 5'd2, 5'd0, 5'd1, 10'h000, 8'h00, 8'h00, 8'h00, 3'b001, 3'b000, 3'b100, 4'b1001, 6'h01, 4'b0000);
    vinst[7] = 32'h0010_0073; vexp[7] = mk(0, 32'd0, 5'd0, 5'd1, 5'd0, 10'h000, 8'h00, 8'h00, 8'h00, 3'b000, 3'b000, 3'b000, 4'b0000, 6'h00, 4'b0100);
    vinst[8] = 32'h0000_0073; vexp[8] = mk(0, 32'd0, 5'd0, 5'd0, 5'd0, 10'h000, 8'h00, 8'h00, 8'h00, 3'b000, 3'b000, 3'b000, 4'b0000, 6'h00, 4'b0001);
    vinst[9] = 32'h3020_0073; vexp[9] = mk(0, 32'd0, 5'd0, 5'd2, 5'd0, 10'h000, 8'h00, 8'h00, 8'h00, 3'b000, 3'b000, 3'b000, 4'b0000, 6'h00, 4'b0010);
    vinst[10] = 32'hFFFF_FFFF; vexp[10] = mk(0, 32'd0, 5'd31, 5'd31, 5'd31, 10'h000, 8'h00, 8'h00, 8'h00, 3'b000, 3'b000, 3'b000, 4'b0000, 6'h00, 4'b1000);
    vinst[11] = 32'h0220_8033;
`ifdef IDU_RV32M_EN
    vexp[11] = mk(0, 32'd0, 5'd1, 5'd2, 5'd0, 10'h000, 8'h01, 8'h00, 8'h00, 3'b001, 3'b001, 3'b001, 4'b1000, 6'h00, 4'b0000);
`else
    vexp[11] = mk(0, 32'd0, 5'd1, 5'd2, 5'd0, 10'h000, 8'h00, 8'h00, 8'h00, 3'b000, 3'b000, 3'b000, 4'b0000, 6'h00, 4'b1000);
`endif
    for (int i = 0; i < NV; i++) begin
      vexp[i].pc = 32'h2000 + 32'(i * 4);
      drive(vinst[i], vexp[i].pc, vexp[i]);
      step();
    end
    bus.in_valid = 1'b0;
    drain();

    // Backpressure: 6 back-to-back pushes into a stalled DEPTH=4 queue
    bus.out_ready = 1'b0;
    accepted = 0;
    for (int i = 0; i < 6; i++) begin
      drive(32'h0050_0093, 32'h3000 + 32'(i * 4),
            mk(32'h3000 + 32'(i * 4), 32'd5, 5'd0, 5'd5, 5'd1, 10'h001, 8'h00, 8'h00, 8'h00,
               3'b001, 3'b010, 3'b001, 4'b1000, 6'h00, 4'b0000));
      step();
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("full_count", 64'(bus.count), 64'd4);
    chk("full_in_ready", 64'(bus.in_ready), 64'd0);
    chk("full_accepted", 64'(accepted), 64'd4);
    step();
    bus.out_ready = 1'b1;
    drain();
    @(negedge clk);
    chk("idle_out_valid", 64'(bus.out_valid), 64'd0);
    chk("idle_payload", {bus.out_pc, bus.out_imm[31:12], bus.out_alu_op, bus.out_rd, bus.out_rf_wen}, 64'd0);

    // Flush with count=3 and a simultaneous push
    step();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(32'h0050_0093, 32'h4000 + 32'(i * 4),
            mk(32'h4000 + 32'(i * 4), 32'd5, 5'd0, 5'd5, 5'd1, 10'h001, 8'h00, 8'h00, 8'h00,
               3'b001, 3'b010, 3'b001, 4'b1000, 6'h00, 4'b0000));
      step();
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("pre_flush_count", 64'(bus.count), 64'd3);
    step();
    bus.flush = 1'b1;
    drive(32'h0000_0013, 32'h4FFC, '0);
    @(negedge clk);
    chk("flush_in_ready", 64'(bus.in_ready), 64'd0);
    chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
    step();
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("post_flush_count", 64'(bus.count), 64'd0);
    chk("post_flush_out_valid", 64'(bus.out_valid), 64'd0);
    step();
    bus.out_ready = 1'b1;
    drive(32'h0050_0093, 32'h5000,
          mk(32'h5000, 32'd5, 5'd0, 5'd5, 5'd1, 10'h001, 8'h00, 8'h00, 8'h00,
             3'b001, 3'b010, 3'b001, 4'b1000, 6'h00, 4'b0000));
    step();
    bus.in_valid = 1'b0;
    drain();

    // Mid-stream reset with count=2 and a push offered in the reset cycle
    step();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(32'h0050_0093, 32'h6000 + 32'(i * 4),
            mk(32'h6000 + 32'(i * 4), 32'd5, 5'd0, 5'd5, 5'd1, 10'h001, 8'h00, 8'h00, 8'h00,
               3'b001, 3'b010, 3'b001, 4'b1000, 6'h00, 4'b0000));
      step();
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_count", 64'(bus.count), 64'd2);
    step();
    rst = 1'b1;
    drive(32'h0000_0013, 32'h6FFC, '0);
    @(negedge clk);
    chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd0);
    step();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("post_rst_count", 64'(bus.count), 64'd0);
    chk("post_rst_in_ready2", 64'(bus.in_ready), 64'd1);
    step();
    bus.out_ready = 1'b1;
    repeat (4) step();
    chk("end_queue", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
